// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller for single-word CPU loads and stores.
// Latency: hit completes 3 clk after acceptance; a miss adds an optional write-back and a refill.
// Backpressure: cpu_ready is high only in IDLE; CPU requests seen in any other state are dropped.
module cache_ctrl #(
   parameter int tag_len    = 13,
   parameter int index_len  = 10,
   parameter int offset_len = 4,
   localparam int LINE_W    = 32 * (2 ** (offset_len - 2)),
   localparam int ADDR_W    = tag_len + index_len + offset_len
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_re,
   input  logic                 cpu_we,
   input  logic [ADDR_W-1:0]    cpu_addr,
   input  logic [31:0]          cpu_wdata,
   output logic                 cpu_ready,
   output logic                 cpu_valid,
   output logic [31:0]          cpu_rdata,
   output logic                 st_we,
   output logic                 st_re,
   output logic [index_len-1:0] st_addr,
   output logic [tag_len-1:0]   st_tag_in,
   output logic [2:0]           st_status_in,
   input  logic [tag_len-1:0]   st_tag_out,
   input  logic [2:0]           st_status_out,
   output logic                 d_we,
   output logic                 d_re,
   output logic [LINE_W-1:0]    d_data_in,
   input  logic [LINE_W-1:0]    d_data_out,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [LINE_W-1:0]    mem_wdata,
   input  logic                 mem_ack,
   input  logic [LINE_W-1:0]    mem_rdata
);

   localparam int WSEL_W = offset_len - 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_COMPARE,
      S_WB,
      S_REFILL,
      S_FILL
   } state_t;

   state_t              state_q;
   logic                op_we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [LINE_W-1:0]   fill_q;
   logic                re_q;
   logic                we_q;
   logic                cpu_valid_q;
   logic [31:0]         cpu_rdata_q;
   logic [tag_len-1:0]  st_tag_in_q;
   logic [2:0]          st_status_in_q;
   logic [LINE_W-1:0]   d_data_in_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [LINE_W-1:0]   mem_wdata_q;

   // Fields of the latched request
   logic [tag_len-1:0]   req_tag;
   logic [index_len-1:0] req_index;
   logic [WSEL_W-1:0]    req_word;
   logic                 hit;
   logic                 victim_dirty;
   logic                 unused_bits;

   assign req_tag      = addr_q[ADDR_W-1 -: tag_len];
   assign req_index    = addr_q[offset_len +: index_len];
   assign req_word     = addr_q[offset_len-1:2];
   assign hit          = st_status_out[0] && (st_tag_out == req_tag);
   assign victim_dirty = st_status_out[0] && st_status_out[1];
   // Byte-lane bits and the reserved status bit carry no meaning here
   assign unused_bits  = ^{addr_q[1:0], st_status_out[2]};

   function automatic logic [31:0] get_word(input logic [LINE_W-1:0] line,
                                            input logic [WSEL_W-1:0] w);
      return line[{w, 5'b0} +: 32];
   endfunction

   function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                  input logic [WSEL_W-1:0] w,
                                                  input logic [31:0]       val);
      logic [LINE_W-1:0] res;
      res = line;
      res[{w, 5'b0} +: 32] = val;
      return res;
   endfunction

   assign cpu_ready    = (state_q == S_IDLE);
   assign cpu_valid    = cpu_valid_q;
   assign cpu_rdata    = cpu_rdata_q;
   assign st_we        = we_q;
   assign d_we         = we_q;
   assign st_re        = re_q;
   assign d_re         = re_q;
   assign st_addr      = req_index;
   assign st_tag_in    = st_tag_in_q;
   assign st_status_in = st_status_in_q;
   assign d_data_in    = d_data_in_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;

   // Controller FSM with all outputs registered; strobes and cpu_valid are single-clk pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         op_we_q        <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         fill_q         <= '0;
         re_q           <= 1'b0;
         we_q           <= 1'b0;
         cpu_valid_q    <= 1'b0;
         cpu_rdata_q    <= '0;
         st_tag_in_q    <= '0;
         st_status_in_q <= '0;
         d_data_in_q    <= '0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
      end else begin
         re_q        <= 1'b0;
         we_q        <= 1'b0;
         cpu_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cpu_re || cpu_we) begin
                  op_we_q <= cpu_we;
                  addr_q  <= cpu_addr;
                  wdata_q <= cpu_wdata;
                  // Read strobe is live during LOOKUP, indexed by the new address
                  re_q    <= 1'b1;
                  state_q <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               state_q <= S_COMPARE;
            end
            S_COMPARE: begin
               if (hit) begin
                  if (op_we_q) begin
                     we_q           <= 1'b1;
                     d_data_in_q    <= put_word(d_data_out, req_word, wdata_q);
                     st_tag_in_q    <= req_tag;
                     st_status_in_q <= 3'b011;
                  end else begin
                     cpu_rdata_q <= get_word(d_data_out, req_word);
                  end
                  cpu_valid_q <= 1'b1;
                  state_q     <= S_IDLE;
               end else if (victim_dirty) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= {st_tag_out, req_index, {offset_len{1'b0}}};
                  mem_wdata_q <= d_data_out;
                  state_q     <= S_WB;
               end else begin
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= {req_tag, req_index, {offset_len{1'b0}}};
                  state_q    <= S_REFILL;
               end
            end
            S_WB: begin
               // Request drops for one clk before the refill is raised
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state_q   <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (!mem_req_q) begin
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= {req_tag, req_index, {offset_len{1'b0}}};
               end else if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  fill_q    <= mem_rdata;
                  state_q   <= S_FILL;
               end
            end
            S_FILL: begin
               we_q        <= 1'b1;
               st_tag_in_q <= req_tag;
               if (op_we_q) begin
                  d_data_in_q    <= put_word(fill_q, req_word, wdata_q);
                  st_status_in_q <= 3'b011;
               end else begin
                  d_data_in_q    <= fill_q;
                  st_status_in_q <= 3'b001;
                  cpu_rdata_q    <= get_word(fill_q, req_word);
               end
               cpu_valid_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl with behavioural tag/data RAMs and a line memory.
// Driver pushes expected completions and memory transactions; monitors pop and compare.
module tb_cache_ctrl;
   localparam int TL = 13;
   localparam int IL = 10;
   localparam int OL = 4;
   localparam int LW = 128;
   localparam int AW = 27;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_re, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [31:0]   cpu_wdata;
   logic          cpu_ready, cpu_valid;
   logic [31:0]   cpu_rdata;
   logic          st_we, st_re, d_we, d_re;
   logic [IL-1:0] st_addr;
   logic [TL-1:0] st_tag_in, st_tag_out;
   logic [2:0]    st_status_in, st_status_out;
   logic [LW-1:0] d_data_in, d_data_out;
   logic          mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata, mem_rdata;

   cache_ctrl dut (
      .clk(clk), .reset(reset),
      .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
      .st_we(st_we), .st_re(st_re), .st_addr(st_addr), .st_tag_in(st_tag_in),
      .st_status_in(st_status_in), .st_tag_out(st_tag_out), .st_status_out(st_status_out),
      .d_we(d_we), .d_re(d_re), .d_data_in(d_data_in), .d_data_out(d_data_out),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_load;
      logic [31:0] data;
      logic        chk_lat;
      int          acc;
   } exp_t;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      logic [LW-1:0] rdata;
      int            delay;
   } mexp_t;

   exp_t  sb[$];
   mexp_t mq[$];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int wr_cnt   = 0;
   int mem_cnt  = 0;
   int strobe_viol = 0;
   int hold_viol   = 0;

   logic [TL-1:0] tag_mem [0:(1<<IL)-1];
   logic [2:0]    stat_mem[0:(1<<IL)-1];
   logic [LW-1:0] dat_mem [0:(1<<IL)-1];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Tag/status and data RAMs: strobes sampled mid-cycle, result driven just after the edge
   initial begin
      logic          re_s, we_s, pre_re, pre_we;
      logic [IL-1:0] a_s;
      logic [TL-1:0] t_s;
      logic [2:0]    s_s;
      logic [LW-1:0] d_s;
      pre_re = 1'b0;
      pre_we = 1'b0;
      st_tag_out = '0;
      st_status_out = '0;
      d_data_out = '0;
      forever begin
         @(negedge clk);
         if (st_re !== d_re || st_we !== d_we) strobe_viol++;
         if ((st_re || d_re) && (st_we || d_we)) strobe_viol++;
         if ((st_re && pre_re) || (st_we && pre_we)) strobe_viol++;
         pre_re = st_re;
         pre_we = st_we;
         re_s = st_re; we_s = st_we; a_s = st_addr;
         t_s = st_tag_in; s_s = st_status_in; d_s = d_data_in;
         @(posedge clk);
         #1;
         if (we_s) begin
            tag_mem[a_s]  = t_s;
            stat_mem[a_s] = s_s;
            dat_mem[a_s]  = d_s;
            wr_cnt++;
         end
         if (re_s) begin
            st_tag_out    = tag_mem[a_s];
            st_status_out = stat_mem[a_s];
            d_data_out    = dat_mem[a_s];
         end
      end
   end

   // Line memory: checks each request against the queue, holds it for the delay, then acks
   initial begin
      mexp_t e;
      logic  aborted;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset && mem_req) begin
            mem_cnt++;
            if (mq.size() == 0) begin
               chk("mem_unexpected_req", {mem_we, mem_addr}, '0);
               mem_ack = 1'b1;
               @(negedge clk);
               mem_ack = 1'b0;
            end else begin
               e = mq.pop_front();
               chk("mem_we", mem_we, e.we);
               chk("mem_addr", mem_addr, e.addr);
               if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
               aborted = 1'b0;
               for (int i = 0; i < e.delay; i++) begin
                  @(negedge clk);
                  if (!mem_req) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (mem_addr !== e.addr || mem_we !== e.we || (e.we && mem_wdata !== e.wdata))
                     hold_viol++;
               end
               if (!aborted) begin
                  mem_ack = 1'b1;
                  mem_rdata = e.rdata;
                  @(negedge clk);
                  mem_ack = 1'b0;
               end
            end
         end
      end
   end

   // Completion monitor
   initial forever begin
      exp_t x;
      @(negedge clk);
      if (reset && cpu_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_cpu_valid", cpu_valid, 1'b0);
         end else begin
            x = sb.pop_front();
            chk("ready_at_valid", cpu_ready, 1'b1);
            if (x.is_load) chk("cpu_rdata", cpu_rdata, x.data);
            if (x.chk_lat) chk("hit_latency", cyc - x.acc + 1, 3);
         end
      end
   end

   task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_data, input logic chk_lat, input logic push);
      exp_t x;
      int   t;
      t = 0;
      while (!cpu_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("ready_timeout", cpu_ready, 1'b1);
      cpu_re = ~we;
      cpu_we = we;
      cpu_addr = addr;
      cpu_wdata = wd;
      x.is_load = ~we;
      x.data = exp_data;
      x.chk_lat = chk_lat;
      x.acc = cyc + 1;
      if (push) sb.push_back(x);
      @(negedge clk);
      cpu_re = 1'b0;
      cpu_we = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) chk(name, sb.size(), 0);
      @(negedge clk);
   endtask

   task automatic push_mem(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                           input logic [LW-1:0] rd, input int dly);
      mexp_t e;
      e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd; e.delay = dly;
      mq.push_back(e);
   endtask

   initial begin
      logic [LW-1:0] l0, l1, l0s, l1s, ln;
      int            w0, m0, acc_n, t;
      l0  = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
      l0s = {32'h33333333, 32'h12345678, 32'hDEADBEEF, 32'h11111111};
      l1  = {32'h44444444, 32'h66666666, 32'h55555555, 32'hCAFEF00D};
      l1s = {32'h44444444, 32'h66666666, 32'hA5A5A5A5, 32'hCAFEF00D};
      for (int i = 0; i < (1 << IL); i++) begin
         tag_mem[i] = '0; stat_mem[i] = '0; dat_mem[i] = '0;
      end
      reset = 1'b0;
      cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", cpu_ready, 1'b1);
      chk("rst_valid", cpu_valid, 1'b0);
      chk("rst_mem_req", {mem_req, mem_we}, 2'b00);
      chk("rst_strobes", {st_re, st_we, d_re, d_we}, 4'b0000);
      chk("rst_rdata", cpu_rdata, 32'h0);
      reset = 1'b1;
      @(negedge clk);

      // Cold load: single refill, no write-back
      push_mem(1'b0, 27'h0000120, '0, l0, 5);
      issue(1'b0, 27'h0000124, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
      wait_done("cold_load_timeout");
      chk("cold_mem_count", mem_cnt, 1);
      chk("cold_status", stat_mem[12'h12], 3'b001);
      chk("cold_tag", tag_mem[12'h12], 13'h0);
      chk("cold_line", dat_mem[12'h12], l0);

      // Repeat load: hit, no memory traffic, no RAM write
      w0 = wr_cnt; m0 = mem_cnt;
      issue(1'b0, 27'h0000124, 32'h0, 32'hDEADBEEF, 1'b1, 1'b1);
      wait_done("hit_load_timeout");
      chk("hit_no_mem", mem_cnt, m0);
      chk("hit_no_write", wr_cnt, w0);

      // Store hit then load back
      issue(1'b1, 27'h0000128, 32'h12345678, 32'h0, 1'b1, 1'b1);
      wait_done("store_timeout");
      ln = dat_mem[12'h12];
      chk("store_word2", ln[95:64], 32'h12345678);
      chk("store_status", stat_mem[12'h12], 3'b011);
      issue(1'b0, 27'h0000128, 32'h0, 32'h12345678, 1'b1, 1'b1);
      wait_done("store_readback_timeout");

      // Conflict miss on dirty line: write-back then refill (refill acked in its first clk)
      m0 = mem_cnt;
      push_mem(1'b1, 27'h0000120, l0s, '0, 3);
      push_mem(1'b0, 27'h4000120, '0, l1, 0);
      issue(1'b0, 27'h4000120, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
      wait_done("evict_timeout");
      chk("evict_mem_count", mem_cnt - m0, 2);
      chk("evict_status", stat_mem[12'h12], 3'b001);
      chk("evict_tag", tag_mem[12'h12], 13'h1000);
      chk("evict_line", dat_mem[12'h12], l1);

      // Dirty the line, then reset in the middle of the write-back
      issue(1'b1, 27'h4000124, 32'hA5A5A5A5, 32'h0, 1'b1, 1'b1);
      wait_done("store2_timeout");
      push_mem(1'b1, 27'h4000120, l1s, '0, 50);
      issue(1'b0, 27'h0000124, 32'h0, 32'h0, 1'b0, 1'b0);
      t = 0;
      while (!mem_req && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("wb_req_seen", mem_req, 1'b1);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst_wb_mem_req", mem_req, 1'b0);
      chk("rst_wb_ready", cpu_ready, 1'b1);
      chk("rst_wb_rdata", cpu_rdata, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_wb_queue", mq.size(), 0);
      m0 = mem_cnt;
      issue(1'b0, 27'h4000128, 32'h0, 32'h66666666, 1'b1, 1'b1);
      wait_done("post_reset_timeout");
      chk("post_reset_no_mem", mem_cnt, m0);

      // cpu_re held for 10 clk: accepted only while ready
      acc_n = 0;
      cpu_addr = 27'h4000128;
      cpu_re = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (cpu_ready) begin
            exp_t x;
            x.is_load = 1'b1; x.data = 32'h66666666; x.chk_lat = 1'b1; x.acc = cyc + 1;
            sb.push_back(x);
            acc_n++;
         end
         @(negedge clk);
      end
      cpu_re = 1'b0;
      wait_done("hold_timeout");
      chk("hold_accepts", acc_n, 4);

      repeat (3) @(negedge clk);
      chk("strobe_rules", strobe_viol, 0);
      chk("mem_hold_stable", hold_viol, 0);
      chk("sb_empty", sb.size(), 0);
      chk("mq_empty", mq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate cache controller.
- Accepts single-word CPU loads and stores, and sequences one Status/Tag RAM and one Data RAM that share an index.
- Both RAMs are single-port with 1-clk read latency: re or we pulses for 1 clk, data is valid the next clk.
- On a miss it performs line write-back and refill over a line-wide memory handshake.

Parameters:
- tag_len, 13, tag bits
- index_len, 10, index bits; 2**index_len lines
- offset_len, 4, byte offset bits; LINE_W = 32*2**(offset_len-2) = 128
- ADDR_W (localparam) = tag_len+index_len+offset_len = 27, byte address

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cpu_re  in  1  load request, sampled only while cpu_ready=1
- cpu_we  in  1  store request, sampled only while cpu_ready=1; if both are high, the store wins
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_ready  out  1  controller idle, can accept a request
- cpu_valid  out  1  1-clk completion pulse, for loads and stores
- cpu_rdata  out  32  load data, held until the next completion
- st_we, st_re  out  1  Status/Tag RAM write/read strobes
- st_addr  out  index_len  shared index to both RAMs
- st_tag_in  out  tag_len  tag to write
- st_status_in  out  3  status to write
- st_tag_out  in  tag_len  tag read back
- st_status_out  in  3  status read back
- d_we, d_re  out  1  Data RAM write/read strobes
- d_data_in  out  LINE_W  line to write
- d_data_out  in  LINE_W  line read back
- mem_req  out  1  memory request
- mem_we  out  1  1 = write-back, 0 = refill
- mem_addr  out  ADDR_W  line-aligned address (offset bits = 0)
- mem_wdata  out  LINE_W  victim line
- mem_ack  in  1  1-clk acknowledge
- mem_rdata  in  LINE_W  refill line, valid with mem_ack

Behaviour:
- Status encoding: bit0 valid, bit1 dirty, bit2 reserved (written 0, ignored on read). Status 0 = invalid line.
- Address fields: tag = addr[ADDR_W-1 -: tag_len], index = addr[offset_len +: index_len], word = addr[offset_len-1:2]. Word 0 occupies line bits [31:0].
- Strobe rules:
  - st_we = d_we and st_re = d_re at all times.
  - The controller never asserts a write and a read strobe in the same clk.
  - Every strobe is a 1-clk pulse.
- Reset (asynchronous, any state): state = IDLE; all strobes, mem_req, mem_we and cpu_valid = 0; cpu_rdata = 0; cpu_ready = 1. Any memory transaction in progress is abandoned. RAM contents are untouched.
- IDLE:
  - cpu_ready = 1.
  - On cpu_re or cpu_we: latch op, addr and wdata; go to LOOKUP.
- LOOKUP: st_re = d_re = 1, st_addr = index; go to COMPARE.
- COMPARE: RAM outputs are valid; hit = status.valid and tag_out == latched tag.
  - Load hit: cpu_rdata <= selected word; cpu_valid = 1 on the next clk; go to IDLE. The request accepted at clk 0 gives cpu_valid at clk 3, with cpu_ready=1 at clk 3.
  - Store hit: assert st_we/d_we with the line (selected word replaced by wdata), the same tag and status 3'b011. Go to IDLE; cpu_valid = 1 on the next clk.
  - Miss with status 3'b?11 (valid and dirty): latch the victim line and tag; go to WB.
  - Any other miss: go to REFILL.
- WB:
  - mem_req = 1, mem_we = 1, mem_addr = {victim_tag, index, 0}, mem_wdata = victim line.
  - All of these are held stable until mem_ack.
  - On mem_ack go to REFILL; mem_req drops for at least 1 clk.
- REFILL:
  - mem_req = 1, mem_we = 0, mem_addr = {tag, index, 0}.
  - On mem_ack capture mem_rdata and go to FILL.
  - mem_ack is honoured in the first clk of mem_req; mem_ack while mem_req=0 is ignored.
- FILL:
  - Write the refilled line (store: word merged with wdata), the new tag, and status 3'b011 (store) or 3'b001 (load).
  - Load: cpu_rdata <= word from the captured line; no RAM re-read.
  - cpu_valid = 1 on the next clk; go to IDLE.
- cpu_ready = 0 in every state except IDLE. CPU inputs outside IDLE are ignored, not queued.
- The controller issues at most one outstanding memory transaction.

Test Plan:
- Cold load of 0x0000124 after reset: one refill with mem_addr=0x0000120. Return line word1=0xDEADBEEF, ack delayed 5 clk. Required: cpu_rdata=0xDEADBEEF, status written 001, no write-back.
- Repeat load of 0x0000124: hit. Required: cpu_valid exactly 3 clk after acceptance, no mem_req, no RAM write.
- Store 0x12345678 to 0x0000128: hit. Required: word2 written, status 011. A following load of 0x0000128 returns 0x12345678.
- Load of 0x4000120 (same index, tag 0x1000): write-back first with mem_addr=0x0000120 and mem_wdata containing 0x12345678, then refill with mem_addr=0x4000120. Required: final status 001, tag 0x1000.
- Assert reset while mem_req=1 in WB: mem_req falls immediately and cpu_ready=1. Required: a new load after release completes normally.
- Hold cpu_re high for 10 clk: accepted only in IDLE clks. Required: each completion gives exactly one cpu_valid, and strobes never overlap a read with a write.
